// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings (the control decoder uses the same constants to drive op)
//   - default latencies
//   - 64-bit {HI,LO} result type
//   - op classification helpers
// Optional feature macro: MDU_MADD_EN (ops 6/7 become MADD/MSUB; otherwise no-ops).
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MSUB  = 3'd7;

  localparam int MDU_MUL_LAT = 5;
  localparam int MDU_DIV_LAT = 10;

  typedef logic [63:0] mdu_res_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops that run the multiply latency window.
  function automatic logic op_is_mul(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) || (op == MDU_MSUB);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  // Ops that write HI or LO on the accepting edge with no busy window.
  function automatic logic op_is_move(input logic [2:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational datapath of the MDU.
// Ports:
//   op      in  3   operation code (mdu_pkg encodings)
//   a, b    in  32  rs / rt operands
//   hi, lo  in  32  current architectural HI/LO
//   res     out 64  new {HI,LO}
//   we      out 1   result should be written (0 for divide by zero and no-ops)
// Optional feature macro: MDU_MADD_EN (ops 6/7 accumulate into {HI,LO}).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output mdu_res_t    res,
  output logic        we
);

  // Low 64 bits of the product of sign-extended operands equals the
  // two's-complement signed product.
  logic [63:0] sprod, uprod;
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes: truncation toward zero falls out naturally,
  // and 0x80000000 / -1 yields 0x80000000 without overflow special-casing.
  logic        sgn, a_neg, b_neg;
  logic [31:0] amag, bmag, uq, ur, q, r;
  assign sgn   = (op == MDU_DIV);
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];
  assign amag  = a_neg ? -a : a;
  assign bmag  = b_neg ? -b : b;
  assign uq    = (bmag == '0) ? '0 : amag / bmag;
  assign ur    = (bmag == '0) ? '0 : amag % bmag;
  assign q     = (a_neg ^ b_neg) ? -uq : uq;
  assign r     = a_neg ? -ur : ur;

  always_comb begin
    res = '0;
    we  = 1'b0;
    case (op)
      MDU_MULT:  begin res = sprod;        we = 1'b1; end
      MDU_MULTU: begin res = uprod;        we = 1'b1; end
      MDU_DIV,
      MDU_DIVU:  begin res = {r, q};       we = (b != '0); end
      MDU_MTHI:  begin res = {a, lo};      we = 1'b1; end
      MDU_MTLO:  begin res = {hi, a};      we = 1'b1; end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin res = {hi, lo} + sprod; we = 1'b1; end
      MDU_MSUB:  begin res = {hi, lo} - sprod; we = 1'b1; end
`endif
      default:   begin res = '0;           we = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: execute-stage multiply/divide unit holding HI/LO.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-low reset
//   start  in  1   MDU instruction valid in E (ignored while busy)
//   op     in  3   operation (mdu_pkg encodings)
//   a, b   in  32  forwarded rs / rt
//   busy   out 1   operation in flight (registered)
//   hi, lo out 32  architectural HI / LO
// Optional feature macro: MDU_MADD_EN (enables MADD/MSUB for ops 6/7).
// State is implied by the counter: IDLE when cnt==0, RUN otherwise.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt, cnt_nxt;
  mdu_res_t      pend, calc_res;
  logic          pend_we, calc_we;
  logic          accept, launch, move, commit;

  mdu_calc u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi),
    .lo  (lo),
    .res (calc_res),
    .we  (calc_we)
  );

  // Output/decode logic
  always_comb begin
    accept = start & ~busy;
    launch = accept & (op_is_div(op) | op_is_mul(op));
    move   = accept & op_is_move(op);
    commit = (cnt == CW'(1));
  end

  // Next-state logic
  always_comb begin
    cnt_nxt = cnt;
    if (accept && op_is_div(op))      cnt_nxt = CW'(DIV_LAT);
    else if (accept && op_is_mul(op)) cnt_nxt = CW'(MUL_LAT);
    else if (cnt != '0)               cnt_nxt = cnt - CW'(1);
  end

  // State register, pending result and HI/LO.
  // MADD/MSUB use HI/LO sampled at acceptance; HI/LO cannot change during the
  // busy window, so this equals their value at the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      pend    <= '0;
      pend_we <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
      if (launch) begin
        pend    <= calc_res;
        pend_we <= calc_we;
      end
      if (move) begin
        {hi, lo} <= calc_res;
      end else if (commit && pend_we) begin
        {hi, lo} <= pend;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed + randomized self-checking bench for mdu against a
// behavioural {HI,LO} model using 64-bit integer arithmetic.
// Optional feature macro: MDU_MADD_EN (selects MADD/MSUB expectations).
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_tests = 0, n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: updates m_hi/m_lo and returns the expected busy length.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    lat = 0;
    case (o)
      3'd0: begin acc = sx * sy; {m_hi, m_lo} = acc; lat = 5; end
      3'd1: begin acc = ux * uy; {m_hi, m_lo} = acc; lat = 5; end
      3'd2: begin
        lat = 10;
        if (y != 0) begin sq = sx / sy; sr = sx % sy; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      3'd3: begin
        lat = 10;
        if (y != 0) begin acc = ux / uy; m_lo = acc[31:0]; acc = ux % uy; m_hi = acc[31:0]; end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
`ifdef MDU_MADD_EN
      3'd6: begin acc = {m_hi, m_lo}; acc = acc + sx * sy; {m_hi, m_lo} = acc; lat = 5; end
      3'd7: begin acc = {m_hi, m_lo}; acc = acc - sx * sy; {m_hi, m_lo} = acc; lat = 5; end
`endif
      default: lat = 0;
    endcase
  endtask

  // Called at a negedge; drives one instruction, measures busy, checks HI/LO.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    int lat, n;
    model(o, x, y, lat);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
    chk({tag, ".busy"}, 64'(n), 64'(lat));
    chk({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    int lat, n;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    #1;
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.hilo", {hi, lo}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    run_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult.lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu.lit", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("div", MDU_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div.lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("mthi11", MDU_MTHI, 32'h11, 32'd0);
    run_op("mtlo22", MDU_MTLO, 32'h22, 32'd0);
    run_op("divu0", MDU_DIVU, 32'h1234, 32'd0);
    chk("divu0.lit", {hi, lo}, 64'h00000011_00000022);
    run_op("divovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf.lit", {hi, lo}, 64'h00000000_80000000);
    run_op("mthi", MDU_MTHI, 32'h1234, 32'd0);
    chk("mthi.lit", {32'd0, hi}, 64'h1234);
    run_op("mtlo", MDU_MTLO, 32'h5678, 32'd0);
    chk("mtlo.lit", {hi, lo}, 64'h00001234_00005678);

    run_op("madd.hi", MDU_MTHI, 32'd0, 32'd0);
    run_op("madd.lo", MDU_MTLO, 32'hFFFFFFFF, 32'd0);
    run_op("madd", MDU_MADD, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    chk("madd.lit", {hi, lo}, 64'h00000001_00000000);
`else
    chk("madd.lit", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    // Start while busy must be ignored.
    model(MDU_DIV, 32'd100, 32'd7, lat);
    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3) begin start = 1'b1; op = MDU_MULT; a = 32'h12345; b = 32'h777; end
      @(negedge clk);
      start = 1'b0;
    end
    chk("ign.busy", 64'(n), 64'(lat));
    chk("ign.hilo", {hi, lo}, 64'h00000002_0000000E);

    // Ignored start, then reset mid-run.
    start = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 6) begin
      n++;
      if (n == 3) begin start = 1'b1; op = MDU_MULT; a = 32'h5; b = 32'h6; end
      @(negedge clk);
      start = 1'b0;
    end
    chk("rr.running", 64'(n), 64'd6);
    reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("rr.busy", {63'd0, busy}, 64'd0);
    chk("rr.hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("rr.late.busy", {63'd0, busy}, 64'd0);
    chk("rr.late.hilo", {hi, lo}, 64'd0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
        2: ry = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rnd", ro, rx, ry);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the execute stage of the five-stage pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, holds the HI/LO architectural registers, and asserts `busy` for a fixed latency so the hazard unit can stall dependent MFHI/MFLO and further MDU instructions in D. Results commit to HI/LO only at the end of the latency window.

## Interface
- `MUL_LAT`, 5, cycles `busy` stays high after an accepted multiply (≥1)
- `DIV_LAT`, 10, cycles `busy` stays high after an accepted divide (≥1)

- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low; clears all state
- `start` in 1: E-stage MDU instruction valid this cycle
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
- `a` in 32: rs operand, already forwarded
- `b` in 32: rt operand, already forwarded
- `busy` out 1: operation in flight
- `hi` out 32: architectural HI
- `lo` out 32: architectural LO

## Operation
- Reset (`reset`=0): `hi`=0, `lo`=0, `busy`=0, counter=0, pending result=0.
- A `start` is accepted only when `busy`=0; `start` while `busy`=1 is ignored (the hazard unit guarantees it never happens; the bench checks it is harmless).
- MTHI/MTLO: write `a` to `hi`/`lo` on the accepting edge; `busy` stays 0.
- MULT/MULTU: 64-bit signed/unsigned product of `a`,`b`; {HI,LO}=product.
- DIV/DIVU: LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0.
- Divide by zero (`b`=0): `busy` still runs DIV_LAT cycles; HI/LO unchanged at commit.
- MADD/MSUB (only with the macro): {HI,LO} ± signed product, modulo 2^64, using HI/LO as they are at the commit edge. These use MUL_LAT.
- On acceptance, the result is computed combinationally from `a`, `b` and `op`. It is latched into a pending register (64 bits plus a valid/no-write flag), and the counter is loaded with the latency.
- States are implied by the counter: IDLE (cnt=0) and RUN (cnt≠0). `busy` = (cnt≠0), registered.

## Timing
- Accept at edge k: `busy`=1 from after edge k for exactly LAT cycles.
- At edge k+LAT, cnt reaches 0: `hi`/`lo` update and `busy` falls on the same edge. The new values are visible while `busy`=0.
- Back-to-back: a `start` in the first cycle with `busy`=0 is accepted. The minimum spacing between two multiplies is MUL_LAT+1 edges.
- MTHI/MTLO latency: 1 edge, no `busy`.
- Reset asserted mid-RUN: the pending result is discarded, `busy` drops immediately (asynchronous), and HI/LO are cleared.
- The unit has no flush input: the pipeline never squashes an instruction already in E.

## Configuration
- `MDU_MADD_EN` defined: ops 6/7 perform MADD/MSUB as above.
- Not defined: ops 6/7 are treated as no-ops. They are accepted, `busy` stays 0, and HI/LO are unchanged.

## Structure
- Package `mdu_pkg`: the op encoding constants (`MDU_MULT`…`MDU_MSUB`), default latencies, and a 64-bit result typedef. The control decoder shares these constants to generate `op`.
- Sub-module `mdu_calc`: purely combinational. It takes `op`, `a`, `b`, `hi`, `lo` and produces a 64-bit result plus a write-enable. The parent holds the counter, the pending register and HI/LO.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 → `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 → `busy` high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with b=0 and prior hi=0x11, lo=0x22 → still busy 10 cycles; hi/lo stay 0x11/0x22.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive edges → hi=0x1234 after 1 edge, lo=0x5678 after the next; `busy` never asserted.
- DIV accepted, then `start`+MULT in cycle 3 of busy (ignored), then `reset`=0 in cycle 6 → `busy`=0 at once, hi=lo=0, and no later commit.
- With `MDU_MADD_EN`: set hi=0, lo=0xFFFFFFFF, then MADD a=1, b=1 → after 5 cycles, hi=1, lo=0. Without the macro, the same sequence leaves hi=0, lo=0xFFFFFFFF with `busy`=0.
